// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: opcodes, ALU codes, WB selects
// and bit positions inside the EX/MEM/WB control bundles.
package decode_pkg;

   localparam int DATA_W = 16;
   localparam int REG_N  = 8;
   localparam int AW     = $clog2(REG_N);

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_NOT  = 6'h01;
   localparam logic [5:0] OP_INC  = 6'h02;
   localparam logic [5:0] OP_DEC  = 6'h03;
   localparam logic [5:0] OP_MOV  = 6'h08;
   localparam logic [5:0] OP_ADD  = 6'h09;
   localparam logic [5:0] OP_SUB  = 6'h0A;
   localparam logic [5:0] OP_AND  = 6'h0B;
   localparam logic [5:0] OP_OR   = 6'h0C;
   localparam logic [5:0] OP_SHL  = 6'h0D;
   localparam logic [5:0] OP_SHR  = 6'h0E;
   localparam logic [5:0] OP_PUSH = 6'h10;
   localparam logic [5:0] OP_POP  = 6'h11;
   localparam logic [5:0] OP_LDD  = 6'h12;
   localparam logic [5:0] OP_STD  = 6'h13;
   localparam logic [5:0] OP_IN   = 6'h14;
   localparam logic [5:0] OP_JMP  = 6'h18;
   localparam logic [5:0] OP_CALL = 6'h19;
   localparam logic [5:0] OP_RET  = 6'h1A;

   localparam logic [3:0] ALU_NONE = 4'd0;
   localparam logic [3:0] ALU_NOT  = 4'd1;
   localparam logic [3:0] ALU_INC  = 4'd2;
   localparam logic [3:0] ALU_DEC  = 4'd3;
   localparam logic [3:0] ALU_MOV  = 4'd4;
   localparam logic [3:0] ALU_ADD  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_SHL  = 4'd9;
   localparam logic [3:0] ALU_SHR  = 4'd10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_IN  = 2'b10;

   localparam int MEM_RD   = 3;
   localparam int MEM_WR   = 2;
   localparam int MEM_ADDR = 1;
   localparam int MEM_DATA = 0;

   localparam int EX_OP_LSB = 2;
   localparam int EX_ALUEN  = 1;
   localparam int EX_SHAMT  = 0;

   localparam int WB_REGW = 2;

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID + write-back facing signal bundle of the decode stage.
interface decode_stage_if;
   import decode_pkg::*;

   logic [5:0]        opcode;
   logic [AW-1:0]     src;
   logic [AW-1:0]     dst;
   logic [3:0]        shiftamount;
   logic              regWrite;
   logic [DATA_W-1:0] WD;
   logic [AW-1:0]     WA;
   logic [DATA_W-1:0] Rsrc;
   logic [DATA_W-1:0] Rdst;
   logic [DATA_W-1:0] Imm;
   logic [3:0]        MEM_signals;
   logic [5:0]        EX_signals;
   logic [2:0]        WB_signals;
   logic              flush;

   modport master (
      output opcode, src, dst, shiftamount, regWrite, WD, WA,
      input  Rsrc, Rdst, Imm, MEM_signals, EX_signals, WB_signals, flush
   );

   modport slave (
      input  opcode, src, dst, shiftamount, regWrite, WD, WA,
      output Rsrc, Rdst, Imm, MEM_signals, EX_signals, WB_signals, flush
   );

endinterface

// File: rtl/register_file.sv
// 8x16 register file, async reset, one write port, two async read ports.
// DECODE_WB_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file
   import decode_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [AW-1:0]     i_wa,
   input  logic [DATA_W-1:0] i_wd,
   input  logic [AW-1:0]     i_ra0,
   input  logic [AW-1:0]     i_ra1,
   output logic [DATA_W-1:0] o_rd0,
   output logic [DATA_W-1:0] o_rd1
);

   logic [DATA_W-1:0] r_mem [REG_N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_wa] <= i_wd;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   // Write-through: the value being written is visible in the same cycle
   assign o_rd0 = (i_we && (i_wa == i_ra0)) ? i_wd : r_mem[i_ra0];
   assign o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_mem[i_ra1];
`else
   assign o_rd0 = r_mem[i_ra0];
   assign o_rd1 = r_mem[i_ra1];
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register file reads/writes plus opcode -> EX/MEM/WB bundles.
// Optional build macro: DECODE_WB_BYPASS_EN (write-back forwarding).
module decode_stage
   import decode_pkg::*;
(
   input logic clk,
   input logic rst,
   decode_stage_if.slave bus
);

   logic [DATA_W-1:0] w_rsrc;
   logic [DATA_W-1:0] w_rdst;
   logic [3:0]        w_aluop;
   logic              w_alu_en;
   logic              w_shamt;
   logic [3:0]        w_mem;
   logic [2:0]        w_wb;
   logic              w_flush;
   logic [5:0]        w_ex;

   register_file u_rf (
      .clk   (clk),
      .rst   (rst),
      .i_we  (bus.regWrite),
      .i_wa  (bus.WA),
      .i_wd  (bus.WD),
      .i_ra0 (bus.src),
      .i_ra1 (bus.dst),
      .o_rd0 (w_rsrc),
      .o_rd1 (w_rdst)
   );

   always_comb begin
      w_aluop = ALU_NONE;
      w_shamt = 1'b0;
      w_mem   = '0;
      w_wb    = '0;
      w_flush = 1'b0;
      unique case (1'b1)
         (bus.opcode == OP_NOT): w_aluop = ALU_NOT;
         (bus.opcode == OP_INC): w_aluop = ALU_INC;
         (bus.opcode == OP_DEC): w_aluop = ALU_DEC;
         (bus.opcode == OP_MOV): w_aluop = ALU_MOV;
         (bus.opcode == OP_ADD): w_aluop = ALU_ADD;
         (bus.opcode == OP_SUB): w_aluop = ALU_SUB;
         (bus.opcode == OP_AND): w_aluop = ALU_AND;
         (bus.opcode == OP_OR):  w_aluop = ALU_OR;
         (bus.opcode == OP_SHL): begin
            w_aluop = ALU_SHL;
            w_shamt = 1'b1;
         end
         (bus.opcode == OP_SHR): begin
            w_aluop = ALU_SHR;
            w_shamt = 1'b1;
         end
         (bus.opcode == OP_PUSH): begin
            w_mem[MEM_WR]   = 1'b1;
            w_mem[MEM_ADDR] = 1'b1;
         end
         (bus.opcode == OP_POP): begin
            w_mem[MEM_RD]   = 1'b1;
            w_mem[MEM_ADDR] = 1'b1;
            w_wb = {1'b1, WB_MEM};
         end
         (bus.opcode == OP_LDD): begin
            w_mem[MEM_RD] = 1'b1;
            w_wb = {1'b1, WB_MEM};
         end
         (bus.opcode == OP_STD): w_mem[MEM_WR] = 1'b1;
         (bus.opcode == OP_IN):  w_wb = {1'b1, WB_IN};
         (bus.opcode == OP_JMP): w_flush = 1'b1;
         (bus.opcode == OP_CALL): begin
            w_mem[MEM_WR]   = 1'b1;
            w_mem[MEM_ADDR] = 1'b1;
            w_mem[MEM_DATA] = 1'b1;
            w_flush = 1'b1;
         end
         (bus.opcode == OP_RET): begin
            w_mem[MEM_RD]   = 1'b1;
            w_mem[MEM_ADDR] = 1'b1;
            w_flush = 1'b1;
         end
         default: ;
      endcase
      w_alu_en = (w_aluop != ALU_NONE);
      if (w_alu_en) begin
         w_wb = {1'b1, WB_ALU};
      end
   end

   assign w_ex = {w_aluop, w_alu_en, w_shamt};

   // Everything reads as zero while reset is held, including forwarded data
   assign bus.Rsrc        = rst ? '0 : w_rsrc;
   assign bus.Rdst        = rst ? '0 : w_rdst;
   assign bus.Imm         = rst ? '0 : {{(DATA_W-4){1'b0}}, bus.shiftamount};
   assign bus.MEM_signals = rst ? '0 : w_mem;
   assign bus.EX_signals  = rst ? '0 : w_ex;
   assign bus.WB_signals  = rst ? '0 : w_wb;
   assign bus.flush       = rst ? 1'b0 : w_flush;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage against a table-driven model.
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_stage_if bus ();

   decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] rsrc;
      logic [15:0] rdst;
      logic [15:0] imm;
      logic [3:0]  mem;
      logic [5:0]  ex;
      logic [2:0]  wb;
      logic        fl;
   } exp_t;

   exp_t        q[$];
   logic [15:0] mdl [8];
   int          n_chk  = 0;
   int          n_pass = 0;
   event        ev_chk;

   // {MEM, EX, WB, flush} straight from the opcode table
   function automatic logic [13:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'h01: return {4'b0000, 6'b000110, 3'b100, 1'b0};
         6'h02: return {4'b0000, 6'b001010, 3'b100, 1'b0};
         6'h03: return {4'b0000, 6'b001110, 3'b100, 1'b0};
         6'h08: return {4'b0000, 6'b010010, 3'b100, 1'b0};
         6'h09: return {4'b0000, 6'b010110, 3'b100, 1'b0};
         6'h0A: return {4'b0000, 6'b011010, 3'b100, 1'b0};
         6'h0B: return {4'b0000, 6'b011110, 3'b100, 1'b0};
         6'h0C: return {4'b0000, 6'b100010, 3'b100, 1'b0};
         6'h0D: return {4'b0000, 6'b100111, 3'b100, 1'b0};
         6'h0E: return {4'b0000, 6'b101011, 3'b100, 1'b0};
         6'h10: return {4'b0110, 6'b000000, 3'b000, 1'b0};
         6'h11: return {4'b1010, 6'b000000, 3'b101, 1'b0};
         6'h12: return {4'b1000, 6'b000000, 3'b101, 1'b0};
         6'h13: return {4'b0100, 6'b000000, 3'b000, 1'b0};
         6'h14: return {4'b0000, 6'b000000, 3'b110, 1'b0};
         6'h18: return {4'b0000, 6'b000000, 3'b000, 1'b1};
         6'h19: return {4'b0111, 6'b000000, 3'b000, 1'b1};
         6'h1A: return {4'b1010, 6'b000000, 3'b000, 1'b1};
         default: return 14'd0;
      endcase
   endfunction

   function automatic logic [15:0] rd_ref(input logic [2:0] idx);
`ifdef DECODE_WB_BYPASS_EN
      if (bus.regWrite === 1'b1 && bus.WA == idx) return bus.WD;
`endif
      return mdl[idx];
   endfunction

   task automatic clr_model();
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (v) clr_model();
   endtask

   // Push the expected response for the current inputs and ask for a sample
   task automatic step();
      exp_t        e;
      logic [13:0] c;
      c = ref_ctrl(bus.opcode);
      if (rst) begin
         e = '{16'h0, 16'h0, 16'h0, 4'h0, 6'h0, 3'h0, 1'b0};
      end else begin
         e.rsrc = rd_ref(bus.src);
         e.rdst = rd_ref(bus.dst);
         e.imm  = {12'h000, bus.shiftamount};
         e.mem  = c[13:10];
         e.ex   = c[9:4];
         e.wb   = c[3:1];
         e.fl   = c[0];
      end
      q.push_back(e);
      -> ev_chk;
      #2;
   endtask

   // Clock edge: the model commits the write the DUT sees on this edge
   task automatic tick();
      @(posedge clk);
      if (rst) clr_model();
      else if (bus.regWrite === 1'b1) mdl[bus.WA] = bus.WD;
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Monitor: pops one expectation per presented sample
   initial begin
      exp_t e;
      forever begin
         @(ev_chk);
         #1;
         if (q.size() == 0) begin
            chk("queue_underflow", 16'd1, 16'd0);
         end else begin
            e = q.pop_front();
            chk("Rsrc", bus.Rsrc, e.rsrc);
            chk("Rdst", bus.Rdst, e.rdst);
            chk("Imm", bus.Imm, e.imm);
            chk("MEM", {12'h0, bus.MEM_signals}, {12'h0, e.mem});
            chk("EX", {10'h0, bus.EX_signals}, {10'h0, e.ex});
            chk("WB", {13'h0, bus.WB_signals}, {13'h0, e.wb});
            chk("flush", {15'h0, bus.flush}, {15'h0, e.fl});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.opcode = 6'h00;
      bus.src = 3'd0;
      bus.dst = 3'd0;
      bus.shiftamount = 4'h0;
      bus.regWrite = 1'b0;
      bus.WD = 16'h0;
      bus.WA = 3'd0;
      set_rst(1'b1);
      #1;
      step();

      // Reset: every index reads zero, all control zero
      for (int i = 0; i < 8; i++) begin
         tick();
         bus.src = 3'(i);
         bus.dst = 3'(7 - i);
         bus.opcode = 6'h19;
         bus.shiftamount = 4'hF;
         bus.regWrite = 1'b1;
         bus.WA = 3'(i);
         bus.WD = 16'hBEEF;
         step();
      end

      tick();
      set_rst(1'b0);
      bus.opcode = 6'h00;
      bus.shiftamount = 4'h0;
      bus.regWrite = 1'b1;
      bus.WA = 3'd0;
      bus.WD = 16'hFFFF;
      bus.src = 3'd0;
      bus.dst = 3'd1;
      step();
      for (int i = 0; i < 3; i++) begin
         tick();
         step();
      end

      bus.WA = 3'd5;
      bus.WD = 16'h1234;
      tick();
      bus.regWrite = 1'b0;
      bus.dst = 3'd5;
      step();

      bus.WA = 3'd3;
      bus.WD = 16'hAAAA;
      tick();
      tick();
      bus.src = 3'd3;
      step();

      // Directed decodes, then every opcode
      bus.opcode = 6'h09;
      step();
      bus.opcode = 6'h0D;
      bus.shiftamount = 4'h7;
      step();
      bus.opcode = 6'h19;
      step();
      tick();
      bus.opcode = 6'h3F;
      step();
      for (int op = 0; op < 64; op++) begin
         tick();
         bus.opcode = 6'(op);
         bus.shiftamount = 4'($urandom_range(15));
         step();
      end

      // Same-cycle write/read of R2
      tick();
      bus.regWrite = 1'b1;
      bus.WA = 3'd2;
      bus.src = 3'd2;
      bus.WD = 16'h00C3;
      step();
      tick();
      bus.regWrite = 1'b0;
      step();

      for (int n = 0; n < 300; n++) begin
         tick();
         bus.opcode = 6'($urandom_range(63));
         bus.src = 3'($urandom_range(7));
         bus.dst = 3'($urandom_range(7));
         bus.shiftamount = 4'($urandom_range(15));
         bus.regWrite = 1'($urandom_range(1));
         bus.WA = 3'($urandom_range(7));
         bus.WD = 16'($urandom);
         step();
      end

      // Load nonzero values everywhere, then pulse reset between edges
      bus.regWrite = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         bus.WA = 3'(i);
         bus.WD = 16'(16'h1111 * (i + 1));
      end
      tick();
      bus.regWrite = 1'b0;
      bus.opcode = 6'h09;
      bus.src = 3'd6;
      bus.dst = 3'd7;
      step();
      tick();
      set_rst(1'b1);
      step();
      set_rst(1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.src = 3'(2 * i);
         bus.dst = 3'(2 * i + 1);
         step();
      end
      tick();
      bus.src = 3'd6;
      bus.dst = 3'd7;
      step();

      #5;
      chk("queue_drain", 16'(q.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction-decode stage of the five-stage pipelined processor.
- Holds the 8x16 general register file. Accepts register writes from write-back and reads the source and destination operands.
- Decodes the 6-bit opcode into the control bundles for the EX, MEM and WB stages.
- Raises flush for control-transfer instructions.

Parameters:
- DATA_W, 16, register and data width.
- REG_N, 8, number of general registers (addressed by 3 bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- opcode  in  6  instruction opcode from the IF/ID register.
- src  in  3  source register index.
- dst  in  3  destination register index.
- shiftamount  in  4  shift amount / short immediate field.
- regWrite  in  1  write-back enable.
- WD  in  16  write-back data.
- WA  in  3  write-back register index.
- Rsrc  out  16  contents of R[src].
- Rdst  out  16  contents of R[dst].
- Imm  out  16  immediate, equal to {12'b0, shiftamount}.
- MEM_signals  out  4  {memRead, memWrite, memAddress (1 = SP, 0 = Rsrc), memData (1 = PC, 0 = Rdst)}.
- EX_signals  out  6  {ALUop[3:0], ALUen, shamtSel}.
- WB_signals  out  3  {regWrite, WBsel[1:0]}; WBsel: 00 = ALU, 01 = memory, 10 = input port.
- flush  out  1  squash the fetched instruction.

Behaviour:
- Reset (async, rst=1): all 8 registers are cleared to 0. Rsrc, Rdst, Imm, MEM_signals, EX_signals, WB_signals and flush are forced to 0 while rst is high.
- Register write: at a rising clk edge, when regWrite=1 and rst=0, R[WA] <= WD. If regWrite is X or 0, no write occurs.
- Register read: combinational; Rsrc = R[src] and Rdst = R[dst].
- src == dst is legal; both outputs then return the same value.
- Control decode is purely combinational from opcode, zero-latency.
- Unlisted opcodes decode as NOP: all bundles 0, flush 0.
- Opcode map, listed as opcode: ALUop/ALUen/shamtSel; MEM; WB; flush. Fields not listed are 0.
  - 0x00 NOP: all 0.
  - 0x01 NOT, 0x02 INC, 0x03 DEC, 0x08 MOV, 0x09 ADD, 0x0A SUB, 0x0B AND, 0x0C OR: ALUop 1,2,3,4,5,6,7,8 respectively; ALUen=1; WB=100.
  - 0x0D SHL: ALUop 9, ALUen=1, shamtSel=1, WB=100.
  - 0x0E SHR: ALUop 10, ALUen=1, shamtSel=1, WB=100.
  - 0x10 PUSH: MEM=0110.
  - 0x11 POP: MEM=1010, WB=101.
  - 0x12 LDD: MEM=1000, WB=101.
  - 0x13 STD: MEM=0100.
  - 0x14 IN: WB=110.
  - 0x18 JMP: flush=1.
  - 0x19 CALL: MEM=0111, flush=1.
  - 0x1A RET: MEM=1010, flush=1.
- Imm is always driven from shiftamount, zero-extended, regardless of opcode.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- When defined: a read whose index equals WA while regWrite=1 returns WD combinationally in the same cycle (write-through forwarding).
- When not defined: the read returns the stored value; the new value is visible only after the rising edge that performs the write.

Decomposition:
- Package decode_pkg: opcode localparams; ALUop codes; WBsel encodings (WB_ALU, WB_MEM, WB_IN); bit-index constants for the MEM, EX and WB bundles; DATA_W and REG_N.
- Sub-module register_file: 8x16 array with async reset, one write port, two async read ports, and the optional bypass.
- The control decoder stays inline in decode_stage.

Test Plan:
- Reset: assert rst for 1 cycle → Rsrc=Rdst=0 for every src/dst index; all control outputs 0 and flush=0.
- Write/read: deassert rst; regWrite=1, WA=0, WD=16'hFFFF; src=0; wait 3 cycles → Rsrc=16'hFFFF.
- Write/read, second register: write R5=16'h1234 → with dst=5, Rdst=16'h1234.
- Write disabled: regWrite=0, WA=3, WD=16'hAAAA → R3 stays 0.
- Decode: opcode=0x09 → EX=010110, WB=100, MEM=0000, flush=0.
- Decode: opcode=0x0D with shiftamount=4'h7 → EX shamtSel=1, Imm=16'h0007.
- Decode: opcode=0x19 → MEM=0111, flush=1.
- Decode: opcode=0x3F → all control 0.
- Bypass: regWrite=1, WA=src=2, WD=16'h00C3 before the clock edge → Rsrc=16'h00C3 with DECODE_WB_BYPASS_EN defined, 0 without; after the edge → 16'h00C3 in both builds.
- Async reset mid-run: registers hold nonzero values; pulse rst between clock edges → all registers read 0 immediately, without waiting for a clock edge.
